sync_down_counter: RTL

Synchronous loadable down-counter and terminal-count timer. It counts in the opposite direction to the team's up-counting ripple counter. Reload value comes from a load port; the block decrements once per enabled cycle and flags expiry with a one-cycle terminal-count pulse. It optionally auto-reloads for periodic tick generation. It is used as a programmable delay or tick source next to the counter blocks in the same design.

---
 rtl/sync_down_counter_pkg.sv | 9 +
 rtl/down_count_core.sv | 22 ++
 rtl/sync_down_counter.sv | 63 ++++++
 3 files changed

// File: rtl/sync_down_counter_pkg.sv
// sync_down_counter_pkg: shared state encoding and default width for the down-counter timer
package sync_down_counter_pkg;
  localparam int WIDTH_DEF = 4;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/down_count_core.sv
// down_count_core: loadable count register that decrements on request and flags a count of one
module down_count_core #(
  parameter int WIDTH = sync_down_counter_pkg::WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_i,
  input  logic [WIDTH-1:0] ld_val_i,
  input  logic             dec_i,
  output logic [WIDTH-1:0] q_o,
  output logic             is_one_o
);
  logic [WIDTH-1:0] q_q, q_d;
  // next count: load beats decrement, otherwise hold
  always_comb q_d = ld_i ? ld_val_i : dec_i ? q_q - WIDTH'(1) : q_q;
  // count register
  always_ff @(posedge clk)
    if (rst) q_q <= '0;
    else q_q <= q_d;
  assign q_o = q_q;
  assign is_one_o = q_q == WIDTH'(1);
endmodule

// File: rtl/sync_down_counter.sv
// sync_down_counter: loadable down-counter with one-cycle terminal-count pulse and optional auto-reload
module sync_down_counter #(
  parameter int WIDTH = sync_down_counter_pkg::WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             busy,
  output logic             done
);
  import sync_down_counter_pkg::*;
  state_e           state_q, state_d;
  logic [WIDTH-1:0] reload_q, reload_d, core_val;
  logic             tc_q, tc_d, core_ld, core_dec, is_one;
  down_count_core #(.WIDTH(WIDTH)) u_core (
    .clk     (clk),
    .rst     (rst),
    .ld_i    (core_ld),
    .ld_val_i(core_val),
    .dec_i   (core_dec),
    .q_o     (q),
    .is_one_o(is_one)
  );
  // sequencing: load restarts from any state; expiry either reloads or parks in DONE at zero
  always_comb begin
    state_d  = state_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    core_ld  = 1'b0;
    core_val = load_val;
    core_dec = 1'b0;
    if (load) begin
      core_ld  = 1'b1;
      reload_d = load_val;
      state_d  = load_val != '0 ? RUN : IDLE;
    end else if (state_q == RUN && en) begin
      tc_d     = is_one;
      core_ld  = is_one && auto_reload;
      core_val = reload_q;
      core_dec = !(is_one && auto_reload);
      state_d  = is_one && !auto_reload ? DONE : RUN;
    end
  end
  // state, reload value and terminal-count registers
  always_ff @(posedge clk)
    if (rst) begin
      state_q  <= IDLE;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  assign tc   = tc_q;
  assign busy = state_q == RUN;
  assign done = state_q == DONE;
endmodule
